// File: rtl/inst_fetch_unit_pkg.sv
// rtl/inst_fetch_unit_pkg.sv - shared types and constants for the instruction fetch stage
// Purpose: PC width, reset PC default, NOP encoding, fetch FSM state enum, PC increment helper.
// Optional feature macro used by the users of this package: FETCH_MISALIGN_CHK_EN.
package inst_fetch_unit_pkg;

    localparam int              PC_W         = 32;
    localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0]     NOP_INSN     = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,     // nothing outstanding, not requesting
        ST_REQ  = 2'd1,     // imem_req high, waiting for grant
        ST_WAIT = 2'd2      // one fetch granted, waiting for rvalid
    } fetch_state_e;

    // 32-bit modulo increment: the top of the address space wraps to 0 silently
    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// rtl/inst_fetch_unit_if.sv - imem request bus and decoder hand-off bundle
// Purpose: groups the instruction-memory request/response signals and the
// {instruction, inst_pc} valid/ready stream toward decode.
// Ports (signals):
//   imem_req, imem_addr            fetch request toward instruction memory
//   imem_gnt, imem_rvalid, imem_rdata  memory grant and in-order read data
//   inst_valid, instruction, inst_pc   buffer head toward decode
//   inst_ready                         decoder accepts head
//   misaligned                         head PC misaligned (FETCH_MISALIGN_CHK_EN only)
// Modports: master = fetch unit, slave = memory/decoder side.
interface inst_fetch_unit_if;
    import inst_fetch_unit_pkg::*;

    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;
    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     instruction;
    logic [PC_W-1:0] inst_pc;
`ifdef FETCH_MISALIGN_CHK_EN
    logic            misaligned;
`endif

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output inst_valid, instruction, inst_pc,
`ifdef FETCH_MISALIGN_CHK_EN
        output misaligned,
`endif
        input  inst_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  inst_valid, instruction, inst_pc,
`ifdef FETCH_MISALIGN_CHK_EN
        input  misaligned,
`endif
        output inst_ready
    );

endinterface

// File: rtl/inst_fetch_unit_fetch_fifo.sv
// rtl/inst_fetch_unit_fetch_fifo.sv - synchronous FIFO with flush for fetched instructions
// Purpose: power-of-2 depth buffer of {pc, instruction} entries.
// Ports: clk, rst_n (async active-low), flush_i, push_i/wdata_i, pop_i,
//        rdata_o (head entry), empty_o, count_o (occupied entries).
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rptr_q;
    logic [AW-1:0]    wptr_q;
    logic [CW-1:0]    cnt_q;

    // Storage is reset so the head reads as zero straight out of reset.
    // A push in the flush cycle lands in the freshly emptied buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            rptr_q <= '0;
            if (push_i) begin
                mem_q[0] <= wdata_i;
                wptr_q   <= AW'(1);
                cnt_q    <= CW'(1);
            end else begin
                wptr_q   <= '0;
                cnt_q    <= '0;
            end
        end else begin
            if (push_i) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= wptr_q + AW'(1);
            end
            if (pop_i) begin
                rptr_q <= rptr_q + AW'(1);
            end
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - instruction fetch stage feeding the decoder
// Purpose: owns the fetch PC, keeps at most one imem fetch outstanding, buffers
// returned words with their PC and hands {instruction, inst_pc} to decode.
// Redirects flush the buffer and discard the in-flight fetch.
// Optional feature macro: FETCH_MISALIGN_CHK_EN (misaligned redirect yields one
// NOP entry flagged misaligned and halts fetch until the next redirect).
// Ports: clk, rst_n (async active-low), redirect/redirect_pc (restart pulse),
//        bus (inst_fetch_unit_if.master: imem request bus + decoder stream).
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC   = RESET_PC_DEF,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                redirect,
    input  logic [PC_W-1:0]     redirect_pc,
    inst_fetch_unit_if.master   bus
);
`ifdef FETCH_MISALIGN_CHK_EN
    localparam int ENTRY_W = 2 * PC_W + 1;
`else
    localparam int ENTRY_W = 2 * PC_W;
`endif
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0] req_pc_q, req_pc_d;     // PC of the outstanding fetch
    logic            drop_q, drop_d;          // discard the next rvalid
    logic            halt_q, halt_d;          // fetch stopped after misaligned redirect

    logic               rsp, rsp_push, push, pop, slot_free, overlap_req;
    logic               keep_out, mis_redirect;
    logic [PC_W-1:0]    tgt_pc;
    logic [ENTRY_W-1:0] push_data, head;
    logic [CW-1:0]      cnt, cnt_after;
    logic               fifo_empty;

    assign rsp = (state_q == ST_WAIT) && bus.imem_rvalid;
    assign pop = bus.inst_valid && bus.inst_ready;

`ifdef FETCH_MISALIGN_CHK_EN
    assign mis_redirect = redirect && (redirect_pc[1:0] != 2'b00);
    assign tgt_pc       = redirect_pc;
`else
    assign mis_redirect = 1'b0;
    assign tgt_pc       = redirect_pc & ~32'h3;
`endif

    // Data returning in a redirect cycle, or owed to a pre-redirect fetch, is dropped.
    assign rsp_push  = rsp && !drop_q && !redirect;
    assign push      = rsp_push || mis_redirect;
    assign cnt_after = cnt + CW'(rsp_push) - CW'(pop);
    assign slot_free = cnt_after < CW'(FIFO_DEPTH);

    // The response cycle may issue the next request so a 1-cycle memory
    // sustains one instruction per cycle with only one fetch outstanding.
    assign overlap_req = rsp && !redirect && !halt_q && slot_free;

    // A fetch still owed by memory after this cycle, which a redirect must drop.
    assign keep_out = ((state_q == ST_WAIT) && !bus.imem_rvalid) ||
                      ((state_q == ST_REQ)  && bus.imem_gnt);

    assign bus.imem_req  = (state_q == ST_REQ) || overlap_req;
    assign bus.imem_addr = fetch_pc_q;

`ifdef FETCH_MISALIGN_CHK_EN
    assign push_data = mis_redirect ? {1'b1, redirect_pc, NOP_INSN}
                                    : {1'b0, req_pc_q, bus.imem_rdata};
    assign bus.misaligned = head[2*PC_W];
`else
    assign push_data = {req_pc_q, bus.imem_rdata};
`endif

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (redirect),
        .push_i  (push),
        .wdata_i (push_data),
        .pop_i   (pop),
        .rdata_o (head),
        .empty_o (fifo_empty),
        .count_o (cnt)
    );

    assign bus.inst_valid  = !fifo_empty;
    assign bus.instruction = head[31:0];
    assign bus.inst_pc     = head[PC_W+31:32];

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        drop_d     = drop_q;
        halt_d     = halt_q;
        if (redirect) begin
            fetch_pc_d = tgt_pc;
            drop_d     = keep_out;
            halt_d     = mis_redirect;
            if (keep_out) begin
                state_d = ST_WAIT;
            end else if (mis_redirect) begin
                state_d = ST_IDLE;
            end else begin
                state_d = ST_REQ;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!halt_q && slot_free) begin
                        state_d = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.imem_gnt) begin
                        req_pc_d   = fetch_pc_q;
                        fetch_pc_d = pc_inc(fetch_pc_q);
                        state_d    = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.imem_rvalid) begin
                        drop_d = 1'b0;
                        if (overlap_req) begin
                            if (bus.imem_gnt) begin
                                req_pc_d   = fetch_pc_q;
                                fetch_pc_d = pc_inc(fetch_pc_q);
                                state_d    = ST_WAIT;
                            end else begin
                                state_d    = ST_REQ;
                            end
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            drop_q     <= 1'b0;
            halt_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            drop_q     <= drop_d;
            halt_q     <= halt_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - directed self-checking bench for inst_fetch_unit
module tb_inst_fetch_unit;
    import inst_fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    int          total = 0;
    int          bad = 0;
    int          lat = 1;
    logic        gnt_en = 1'b1;

    inst_fetch_unit_if bus();

    assign bus.imem_gnt = bus.imem_req & gnt_en;

    inst_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory: samples the request handshake late in the cycle, answers 'lat' cycles after grant.
    initial begin : mem_model
        logic        fire;
        logic [31:0] fire_addr;
        logic        pend;
        logic [31:0] pend_addr;
        int          left;
        pend = 1'b0;
        left = 0;
        pend_addr = 32'h0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            #4;
            fire      = bus.imem_req & bus.imem_gnt & rst_n;
            fire_addr = bus.imem_addr;
            @(posedge clk);
            #1;
            bus.imem_rvalid = 1'b0;
            if (!rst_n) begin
                pend = 1'b0;
            end else begin
                if (fire) begin
                    pend = 1'b1;
                    pend_addr = fire_addr;
                    left = lat;
                end
                if (pend) begin
                    left--;
                    if (left == 0) begin
                        bus.imem_rvalid = 1'b1;
                        bus.imem_rdata  = mem_word(pend_addr);
                        pend = 1'b0;
                    end
                end
            end
        end
    end

    task automatic do_reset(input int l, input logic ge);
        rst_n = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        lat = l;
        gnt_en = ge;
        bus.inst_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_redirect(input logic [31:0] pc);
        redirect = 1'b1;
        redirect_pc = pc;
        @(negedge clk);
        redirect = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!bus.inst_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.inst_valid) chk({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bus.inst_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req",   bus.imem_req,    0);
        chk("rst_addr",  bus.imem_addr,   32'h0);
        chk("rst_valid", bus.inst_valid,  0);
        chk("rst_insn",  bus.instruction, 32'h0);
        chk("rst_pc",    bus.inst_pc,     32'h0);

        // 1: streaming with 1-cycle memory
        rst_n = 1'b1;
        @(negedge clk);
        chk("t1_req1",   bus.imem_req,   1);
        chk("t1_addr1",  bus.imem_addr,  32'h0);
        chk("t1_valid1", bus.inst_valid, 0);
        @(negedge clk);
        chk("t1_valid2", bus.inst_valid, 0);
        chk("t1_addr2",  bus.imem_addr,  32'h4);
        @(negedge clk);
        chk("t1_valid3", bus.inst_valid,  1);
        chk("t1_pc3",    bus.inst_pc,     32'h0);
        chk("t1_insn3",  bus.instruction, mem_word(32'h0));
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk("t1_valid", bus.inst_valid,  1);
            chk("t1_pc",    bus.inst_pc,     32'(4 * i));
            chk("t1_insn",  bus.instruction, mem_word(32'(4 * i)));
        end

        // 2: decoder stalls; head pc 20 stays, buffer fills to two entries
        bus.inst_ready = 1'b0;
        repeat (10) @(negedge clk);
        chk("t2_valid", bus.inst_valid, 1);
        chk("t2_head",  bus.inst_pc,    32'd20);
        chk("t2_req",   bus.imem_req,   0);
        bus.inst_ready = 1'b1;
        @(negedge clk);
        chk("t2_pc2",   bus.inst_pc,    32'd24);
        chk("t2_val2",  bus.inst_valid, 1);
        @(negedge clk);
        chk("t2_empty", bus.inst_valid, 0);
        @(negedge clk);
        chk("t2_pc3",   bus.inst_pc,    32'd28);
        chk("t2_val3",  bus.inst_valid, 1);

        // 3: redirect while WAIT with 3-cycle memory
        do_reset(3, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("t3_wait_req", bus.imem_req, 0);
        pulse_redirect(32'h100);
        wait_valid("t3");
        chk("t3_pc",   bus.inst_pc,     32'h100);
        chk("t3_insn", bus.instruction, mem_word(32'h100));

        // 4: redirect together with rvalid and pop
        do_reset(1, 1'b1);
        repeat (5) @(negedge clk);
        chk("t4_pop_valid", bus.inst_valid, 1);
        chk("t4_pop_pc",    bus.inst_pc,    32'h8);
        pulse_redirect(32'h200);
        chk("t4_flushed",   bus.inst_valid, 0);
        wait_valid("t4");
        chk("t4_pc",   bus.inst_pc,     32'h200);
        chk("t4_insn", bus.instruction, mem_word(32'h200));

        // 5: grant withheld; redirect in REQ moves the address next cycle
        do_reset(1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_req",  bus.imem_req,  1);
            chk("t5_addr", bus.imem_addr, 32'h0);
        end
        pulse_redirect(32'h300);
        chk("t5_req_r",  bus.imem_req,  1);
        chk("t5_addr_r", bus.imem_addr, 32'h300);
        @(negedge clk);
        chk("t5_addr_h", bus.imem_addr, 32'h300);
        gnt_en = 1'b1;
        wait_valid("t5");
        chk("t5_pc", bus.inst_pc, 32'h300);

        // 6: misaligned redirect
        do_reset(1, 1'b1);
        repeat (4) @(negedge clk);
`ifdef FETCH_MISALIGN_CHK_EN
        pulse_redirect(32'h102);
        chk("t6_valid", bus.inst_valid,  1);
        chk("t6_pc",    bus.inst_pc,     32'h102);
        chk("t6_insn",  bus.instruction, 32'h0000_0013);
        chk("t6_mis",   bus.misaligned,  1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t6_halt_req", bus.imem_req,   0);
            chk("t6_halt_val", bus.inst_valid, 0);
        end
        pulse_redirect(32'h400);
        wait_valid("t6");
        chk("t6_pc2",  bus.inst_pc,    32'h400);
        chk("t6_mis2", bus.misaligned, 0);
`else
        pulse_redirect(32'h106);
        wait_valid("t6");
        chk("t6_pc",   bus.inst_pc,     32'h104);
        chk("t6_insn", bus.instruction, mem_word(32'h104));
`endif

        // 7: redirect on a granted request, then PC wrap past the top
        do_reset(1, 1'b1);
        @(negedge clk);
        pulse_redirect(32'hFFFF_FFF8);
        wait_valid("t7");
        chk("t7_pc0",   bus.inst_pc,     32'hFFFF_FFF8);
        chk("t7_insn0", bus.instruction, mem_word(32'hFFFF_FFF8));
        @(negedge clk);
        chk("t7_pc1",   bus.inst_pc,     32'hFFFF_FFFC);
        @(negedge clk);
        chk("t7_pc2",   bus.inst_pc,     32'h0);
        chk("t7_insn2", bus.instruction, mem_word(32'h0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
